ps2_bcd_entry: RTL

Parametrised PS/2 keyboard numeric-entry block for the signal generator front end. It samples the raw PS/2 clock/data pins in the system clock domain and validates every 11-bit frame: start, parity, stop and an inactivity timeout. It decodes make/break/extended scan codes with auto-repeat suppression and maintains a DIGITS-wide BCD entry register with backspace, clear and Enter-to-commit. The committed value feeds the frequency/amplitude setting logic.

---
 rtl/ps2_pkg.sv | 51 +++++
 rtl/ps2_bcd_entry_if.sv | 24 ++
 rtl/ps2_bcd_entry_rx_frame.sv | 99 +++++++++
 rtl/ps2_bcd_entry.sv | 111 +++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - scan codes, receiver state and scan-to-digit helper for ps2_bcd_entry
// Optional macro PS2_KEYPAD_EN enables numeric keypad digits and keypad Enter.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Digit n lives in bits [8n+7:8n].
  localparam logic [79:0] SC_DIGITS =
    {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};
  localparam logic [79:0] SC_KEYPAD =
    {8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73, 8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70};

`ifdef PS2_KEYPAD_EN
  localparam bit KEYPAD_EN = 1'b1;
`else
  localparam bit KEYPAD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } digit_t;

  function automatic digit_t scan_to_digit(input logic [7:0] code, input logic ext);
    digit_t r;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      if (!ext && code == SC_DIGITS[8*i +: 8]) begin
        r.valid = 1'b1;
        r.digit = 4'(i);
      end
      if (KEYPAD_EN && !ext && code == SC_KEYPAD[8*i +: 8]) begin
        r.valid = 1'b1;
        r.digit = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_bcd_entry_if.sv
// rtl/ps2_bcd_entry_if.sv - PS/2 pins, enable and BCD entry outputs of ps2_bcd_entry
interface ps2_bcd_entry_if #(
  parameter int DIGITS = 5
);
  logic                  PS2Clk;
  logic                  PS2Data;
  logic                  ENABLE;
  logic [4*DIGITS-1:0]   ENTRY;
  logic [4*DIGITS-1:0]   VALUE;
  logic                  COMMIT;
  logic                  KEY_VALID;
  logic                  OVERFLOW;
  logic                  FRAME_ERR;

  modport master (
    output PS2Clk, PS2Data, ENABLE,
    input  ENTRY, VALUE, COMMIT, KEY_VALID, OVERFLOW, FRAME_ERR
  );

  modport slave (
    input  PS2Clk, PS2Data, ENABLE,
    output ENTRY, VALUE, COMMIT, KEY_VALID, OVERFLOW, FRAME_ERR
  );
endinterface

// File: rtl/ps2_bcd_entry_rx_frame.sv
// rtl/ps2_bcd_entry_rx_frame.sv - PS/2 pin synchronisers, 11-bit frame receiver and timeout
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0] clk_sync_q, data_sync_q;
  logic       clk_prev_q, edge_q, bit_q;
  rx_state_t  state_q, state_d;
  logic [2:0] bitcnt_q;
  logic [7:0] shift_q;
  logic       par_ok_q;
  logic [TW-1:0] tcnt_q;
  logic       byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;
  logic       timeout;

  // Edge and its data bit are registered together so they stay aligned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      edge_q      <= 1'b0;
      bit_q       <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
      edge_q      <= clk_prev_q & ~clk_sync_q[1];
      bit_q       <= data_sync_q[1];
    end
  end

  assign timeout = (state_q != RX_IDLE) && !edge_q && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RX_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:   if (edge_q && !bit_q)            state_d = RX_DATA;
      RX_DATA:   if (edge_q && bitcnt_q == 3'd7)  state_d = RX_PARITY;
      RX_PARITY: if (edge_q)                      state_d = RX_STOP;
      RX_STOP:   if (edge_q)                      state_d = RX_IDLE;
      default:                                    state_d = RX_IDLE;
    endcase
    if (timeout) state_d = RX_IDLE;
  end

  always_comb begin
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (state_q == RX_STOP && edge_q) begin
      if (bit_q && par_ok_q) byte_valid_d = 1'b1;
      else                   frame_err_d  = 1'b1;
    end
    if (timeout) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bitcnt_q     <= 3'd0;
      shift_q      <= 8'h00;
      par_ok_q     <= 1'b0;
      tcnt_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      if (state_q == RX_IDLE || edge_q) tcnt_q <= '0;
      else                              tcnt_q <= tcnt_q + TW'(1);
      if (state_q == RX_IDLE) bitcnt_q <= 3'd0;
      if (state_q == RX_DATA && edge_q) begin
        shift_q  <= {bit_q, shift_q[7:1]};
        bitcnt_q <= bitcnt_q + 3'd1;
      end
      if (state_q == RX_PARITY && edge_q) par_ok_q <= ^{shift_q, bit_q};
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_bcd_entry.sv
// rtl/ps2_bcd_entry.sv - PS/2 scan-code decoder driving a BCD entry register with commit
// Optional macro PS2_KEYPAD_EN (see ps2_pkg) adds keypad digits and E0 5A Enter.
module ps2_bcd_entry
  import ps2_pkg::*;
#(
  parameter int DIGITS         = 5,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic             CLK,
  input  logic             RESET_N,
  ps2_bcd_entry_if.slave   bus
);
  localparam int EW = 4 * DIGITS;

  logic [7:0]    rx_byte;
  logic          rx_valid, rx_err;
  logic [EW-1:0] entry_q, entry_d, value_q, value_d;
  logic [7:0]    last_q, last_d;
  logic          brk_q, brk_d, ext_q, ext_d;
  logic          kv_q, kv_d, ov_q, ov_d, commit_q, commit_d;
  digit_t        dig;

  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk_i        (CLK),
    .rst_ni       (RESET_N),
    .ps2_clk_i    (bus.PS2Clk),
    .ps2_data_i   (bus.PS2Data),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_err)
  );

  assign dig = scan_to_digit(rx_byte, ext_q);

  always_comb begin
    entry_d  = entry_q;
    value_d  = value_q;
    last_d   = last_q;
    brk_d    = brk_q;
    ext_d    = ext_q;
    kv_d     = 1'b0;
    ov_d     = 1'b0;
    commit_d = 1'b0;
    if (!bus.ENABLE) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        if (rx_byte == last_q) last_d = 8'h00;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (rx_byte != last_q) begin
        // A make equal to last_make is typematic repeat and falls through untouched.
        last_d = rx_byte;
        ext_d  = 1'b0;
        if (dig.valid) begin
          if (entry_q[EW-1 -: 4] == 4'd0) begin
            entry_d = (entry_q << 4) | EW'(dig.digit);
            kv_d    = 1'b1;
          end else begin
            ov_d = 1'b1;
          end
        end else if (!ext_q && rx_byte == SC_BKSP) begin
          entry_d = entry_q >> 4;
          kv_d    = 1'b1;
        end else if (!ext_q && rx_byte == SC_ESC) begin
          entry_d = '0;
          kv_d    = 1'b1;
        end else if (rx_byte == SC_ENTER && (!ext_q || KEYPAD_EN)) begin
          value_d  = entry_q;
          entry_d  = '0;
          commit_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      entry_q  <= '0;
      value_q  <= '0;
      last_q   <= 8'h00;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      kv_q     <= 1'b0;
      ov_q     <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      entry_q  <= entry_d;
      value_q  <= value_d;
      last_q   <= last_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      kv_q     <= kv_d;
      ov_q     <= ov_d;
      commit_q <= commit_d;
    end
  end

  assign bus.ENTRY     = entry_q;
  assign bus.VALUE     = value_q;
  assign bus.COMMIT    = commit_q;
  assign bus.KEY_VALID = kv_q;
  assign bus.OVERFLOW  = ov_q;
  assign bus.FRAME_ERR = rx_err;

endmodule
